// File: rtl/fir_pkg.sv
// fir_pkg: constants shared between the stream adapter and the scheduled
// 8-bit FIR datapath. The schedule numbers must agree with the FIR
// controller, otherwise x/y alignment is lost.
package fir_pkg;

  localparam int FIR_WIDTH     = 8;  // x/y sample width
  localparam int FIR_SCHED_LEN = 8;  // cycles per FIR schedule period
  localparam int FIR_Y_PHASE   = 7;  // phase at which y is valid for the sample issued at phase 0

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-bit pointers for full/empty.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write request and data
//   pop, pop_data     read request; pop_data is the current head (show-ahead)
//   full, empty       status from the registered pointers
//   count             number of stored entries (0..DEPTH)
//
// A push while full is accepted only when a pop happens in the same cycle;
// callers that must refuse pushes on full gate push themselves.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with different wrap bits means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fir_stream_adapter.sv
// fir_stream_adapter: valid/ready front end for the handshake-less scheduled
// FIR. Samples are buffered in an input FIFO and issued onto x once per
// schedule period; the matching y is captured into an output FIFO and
// returned downstream.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_data/in_valid/in_ready     upstream sample stream
//   x                    sample driven to the FIR (held for a whole period)
//   y                    FIR result, valid at phase Y_PHASE
//   out_data/out_valid/out_ready  downstream result stream
//   phase                current schedule phase (debug/alignment)
//   overflow             sticky: a result was dropped because the output FIFO was full
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid does not wait for ready, and a source holds its data steady while
// valid is high and ready is low. in_ready and out_valid come only from
// registered FIFO state.
module fir_stream_adapter
  import fir_pkg::*;
#(
  parameter int WIDTH     = FIR_WIDTH,
  parameter int SCHED_LEN = FIR_SCHED_LEN,
  parameter int Y_PHASE   = FIR_Y_PHASE,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             x,
  input  logic [WIDTH-1:0]             y,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(SCHED_LEN)-1:0] phase,
  output logic                         overflow
);

  localparam int PW = $clog2(SCHED_LEN);
  localparam logic [PW-1:0] LAST_PH = PW'(SCHED_LEN - 1);
  localparam logic [PW-1:0] CAP_PH  = PW'(Y_PHASE);

  logic                       tag;  // current period carries a real sample
  logic                       issue;
  logic                       capture;
  logic                       in_push;
  logic                       in_pop;
  logic                       out_pop;
  logic [WIDTH-1:0]           in_head;
  logic                       in_full;
  logic                       in_empty;
  logic [$clog2(IN_DEPTH):0]  in_count;
  logic [WIDTH-1:0]           out_head;
  logic                       out_full;
  logic                       out_empty;
  logic [$clog2(OUT_DEPTH):0] out_count;
  logic                       unused_counts;

  // Occupancy counts are kept on the FIFO interface for debug probing only.
  assign unused_counts = ^{in_count, out_count};

  assign in_ready = !in_full;
  assign in_push  = in_valid && in_ready;

  // The edge that ends the last phase starts a new FIR period, so the popped
  // sample is on x throughout phase 0, when the FIR samples it. A sample
  // pushed on this same edge is not yet visible at the head.
  assign issue  = (phase == LAST_PH);
  assign in_pop = issue && !in_empty;

  assign capture   = (phase == CAP_PH) && tag;
  assign out_valid = !out_empty;
  assign out_pop   = out_valid && out_ready;
  assign out_data  = out_empty ? '0 : out_head;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_push),
    .push_data (in_data),
    .pop       (in_pop),
    .pop_data  (in_head),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count)
  );

  // A capture into a full FIFO succeeds when the consumer pops that cycle.
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (y),
    .pop       (out_pop),
    .pop_data  (out_head),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      x        <= '0;
      tag      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      phase <= issue ? '0 : phase + 1'b1;
      if (issue) begin
        // Empty FIFO: zero-stuff the period and mark it as a bubble.
        x   <= in_empty ? '0 : in_head;
        tag <= !in_empty;
      end
      if (capture && out_full && !out_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_stream_adapter.sv
// Bench for fir_stream_adapter. A small FIR stand-in drives y = x ^ 8'h26 at
// phase 7 (random noise at every other phase), so expected results are
// hand-computed constants.
module tb_fir_stream_adapter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x;
  logic [7:0] y = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] phase;
  logic       overflow;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  logic [2:0] bph;              // bench copy of the schedule phase
  logic       held = 1'b0;
  logic [7:0] held_data = '0;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic [7:0] ex;
    logic       eov;
    logic [7:0] eod;
  } vec_t;
  vec_t tv[20];

  fir_stream_adapter dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .phase     (phase),
    .overflow  (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- FIR stand-in ----------------
  always @(posedge clk) bph <= reset ? 3'd0 : bph + 3'd1;

  always @(negedge clk) y = (bph == 3'd7) ? (x ^ 8'h26) : 8'($urandom);

  // ---------------- scoreboard ----------------
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  always @(negedge clk) begin
    #2;
    if (reset) begin
      held = 1'b0;
    end else begin
      check("phase", phase, bph);
      if (held) check("out_hold", out_data, held_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got %0h, no result expected at %0t", out_data, $time);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_phase0();
    for (int i = 0; i < 8 && bph != 3'd0; i++) tick();
  endtask

  task automatic push_one(input logic [7:0] d, input bit expect_out);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 64 && !in_ready; i++) tick();
    check("push_ready", in_ready, 1'b1);
    if (expect_out) exp_q.push_back(d ^ 8'h26);
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int accepted;

    // Reset alignment + single sample: cycle c is phase c%8 of the run.
    for (int c = 0; c < 20; c++) begin
      tv[c] = '{iv:   (c == 3),
                id:   (c == 3) ? 8'h12 : 8'h00,
                ordy: (c >= 17),
                ex:   (c >= 8 && c < 16) ? 8'h12 : 8'h00,
                eov:  (c == 16 || c == 17),
                eod:  (c == 16 || c == 17) ? 8'h34 : 8'h00};
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(8'h34);
    for (int c = 0; c < 20; c++) begin
      check("tbl_x", x, tv[c].ex);
      check("tbl_out_valid", out_valid, tv[c].eov);
      check("tbl_out_data", out_data, tv[c].eod);
      check("tbl_in_ready", in_ready, 1'b1);
      check("tbl_overflow", overflow, 1'b0);
      in_valid  = tv[c].iv;
      in_data   = tv[c].id;
      out_ready = tv[c].ordy;
      tick();
    end
    in_valid = 1'b0;

    // Bubbles: no input for three periods.
    for (int i = 0; i < 24; i++) begin
      check("bubble_x", x, 8'h00);
      check("bubble_out_valid", out_valid, 1'b0);
      tick();
    end

    // Input backpressure: six back-to-back samples into a 4-entry FIFO.
    wait_phase0();
    accepted = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 80 && accepted < 6; i++) begin
      in_data = 8'h50 + 8'(accepted);
      if (i == 4) check("in_ready_full", in_ready, 1'b0);
      if (i == 8) begin
        check("in_ready_after_pop", in_ready, 1'b1);
        check("bp_x_first", x, 8'h50);
      end
      if (in_ready) begin
        exp_q.push_back(in_data ^ 8'h26);
        accepted++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", accepted, 6);
    for (int k = 1; k < 6; k++) begin
      check("bp_x_order", x, 8'h50 + 8'(k));
      repeat (8) tick();
    end
    check("bp_x_idle", x, 8'h00);
    check("bp_drained", exp_q.size(), 0);

    // Capture into a full output FIFO while it pops: nothing dropped.
    wait_phase0();
    out_ready = 1'b0;
    push_one(8'h10, 1'b1);
    push_one(8'h11, 1'b1);
    push_one(8'h12, 1'b1);
    repeat (28) tick();
    check("pc_head", out_data, 8'h36);
    check("pc_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pc_overflow", overflow, 1'b0);
    check("pc_next_head", out_data, 8'h37);
    out_ready = 1'b1;
    repeat (4) tick();
    check("pc_drained", exp_q.size(), 0);
    check("pc_empty", out_valid, 1'b0);

    // Output overflow: third result dropped, flag sticky.
    wait_phase0();
    out_ready = 1'b0;
    push_one(8'h87, 1'b1);
    push_one(8'h84, 1'b1);
    push_one(8'h85, 1'b0);
    repeat (28) tick();
    check("ovf_before", overflow, 1'b0);
    tick();
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", out_data, 8'hA1);
    check("ovf_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    repeat (4) tick();
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_empty", out_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // Reset mid-operation: two queued samples, one buffered result.
    wait_phase0();
    out_ready = 1'b0;
    push_one(8'h01, 1'b0);
    push_one(8'h02, 1'b0);
    push_one(8'h03, 1'b0);
    push_one(8'h04, 1'b0);
    repeat (17) tick();
    check("rst_pre_phase", phase, 3'd5);
    check("rst_pre_valid", out_valid, 1'b1);
    reset = 1'b1;
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_phase", phase, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_x", x, 8'h00);
    exp_q.delete();
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (32) tick();
    check("rst_no_stale", out_valid, 1'b0);
    check("rst_x_idle", x, 8'h00);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
